sequenciador_programa: RTL

SEQUENCIADOR_PROGRAMA -- requirements
Module: sequenciador_programa

---
 rtl/sequenciador_programa.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sequenciador_programa.sv
// rtl/sequenciador_programa.sv - fetches program words and issues them to the processor one at a time.
// Optional WAIT watchdog enabled by defining SEQ_TIMEOUT_EN.
module sequenciador_programa #(
  parameter int ADDR_W      = 5,
  parameter int PROG_LEN    = 32,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Done,
  input  logic [15:0]       MemData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [15:0]       DIN,
  output logic              Run,
  output logic              Busy,
  output logic              Halted,
  output logic [15:0]       InstrCount,
  output logic              Timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_HALTED
  } state_t;

  localparam logic [ADDR_W:0] LAST_PC  = (ADDR_W+1)'(PROG_LEN);
  localparam logic [15:0]     HALT_WORD = 16'hFFFF;

  state_t          state, state_nx;
  logic [ADDR_W:0] pc, pc_nx;
  logic [15:0]     din_nx;
  logic [15:0]     count_nx;

`ifdef SEQ_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
  logic             timeout_q, timeout_nx;

  assign Timeout = timeout_q;
`else
  assign Timeout = 1'b0;
`endif

  assign Busy   = (state != S_IDLE) && (state != S_HALTED);
  assign Halted = (state == S_HALTED);

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    din_nx   = DIN;
    count_nx = InstrCount;
    MemAddr  = pc[ADDR_W-1:0];
    Run      = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    wait_cnt_nx = wait_cnt;
    timeout_nx  = timeout_q;
`endif

    case (state)
      S_IDLE, S_HALTED: begin
        if (Start) begin
          pc_nx    = '0;
          count_nx = '0;
          state_nx = S_FETCH;
`ifdef SEQ_TIMEOUT_EN
          timeout_nx = 1'b0;
`endif
        end
      end

      S_FETCH: state_nx = S_LOAD;

      S_LOAD: begin
        // Prefetch the following word so an mvi immediate is ready in ISSUE.
        MemAddr = pc[ADDR_W-1:0] + ADDR_W'(1);
        if (MemData == HALT_WORD) begin
          state_nx = S_HALTED;
        end else begin
          din_nx   = MemData;
          state_nx = S_ISSUE;
        end
      end

      S_ISSUE: begin
        Run = 1'b1;
        if (DIN[8:6] == 3'b001) begin
          din_nx = MemData;
          pc_nx  = pc + (ADDR_W+1)'(2);
        end else begin
          pc_nx  = pc + (ADDR_W+1)'(1);
        end
        state_nx = S_WAIT;
`ifdef SEQ_TIMEOUT_EN
        wait_cnt_nx = '0;
`endif
      end

      S_WAIT: begin
        if (Done) begin
          count_nx = InstrCount + 16'd1;
          state_nx = (pc >= LAST_PC) ? S_HALTED : S_FETCH;
        end
`ifdef SEQ_TIMEOUT_EN
        // Done on the final allowed cycle counts as a normal completion.
        else if (wait_cnt == CNT_LAST) begin
          timeout_nx = 1'b1;
          state_nx   = S_HALTED;
        end else begin
          wait_cnt_nx = wait_cnt + CNT_W'(1);
        end
`endif
      end

      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      DIN        <= '0;
      InstrCount <= '0;
`ifdef SEQ_TIMEOUT_EN
      wait_cnt   <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      DIN        <= din_nx;
      InstrCount <= count_nx;
`ifdef SEQ_TIMEOUT_EN
      wait_cnt   <= wait_cnt_nx;
      timeout_q  <= timeout_nx;
`endif
    end
  end

endmodule
